// File: rtl/vlsu_mem_sequencer.sv
// Vector load/store memory sequencer: walks the active elements of a vector
// access, issuing one scalar memory request per element and assembling loads.
module vlsu_mem_sequencer #(
  parameter int unsigned NLANES = 4,
  parameter int unsigned XLEN   = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     is_store,
  input  logic [2:0]               width,
  input  logic [2:0]               vl,
  input  logic [XLEN-1:0]          base_addr,
  input  logic [XLEN-1:0]          offset0,
  input  logic [XLEN-1:0]          offset1,
  input  logic [XLEN-1:0]          offset2,
  input  logic [XLEN-1:0]          offset3,
  input  logic [NLANES*XLEN-1:0]   store_data,
  output logic                     mem_req_valid,
  input  logic                     mem_req_ready,
  output logic [XLEN-1:0]          mem_addr,
  output logic                     mem_we,
  output logic [3:0]               mem_be,
  output logic [XLEN-1:0]          mem_wdata,
  input  logic                     mem_rvalid,
  input  logic [XLEN-1:0]          mem_rdata,
  output logic                     busy,
  output logic                     done,
  output logic                     err,
  output logic [NLANES*XLEN-1:0]   load_data
);

  localparam int unsigned IDXW = 2;
  localparam logic [2:0] W_BYTE = 3'b000;
  localparam logic [2:0] W_HALF = 3'b101;
  localparam logic [2:0] W_WORD = 3'b110;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

  state_t                   r_state;
  state_t                   w_next;
  logic                     r_is_store;
  logic [2:0]               r_width;
  logic [2:0]               r_vl;
  logic [XLEN-1:0]          r_base;
  logic [XLEN-1:0]          r_off [NLANES];
  logic [NLANES*XLEN-1:0]   r_sdata;
  logic [NLANES*XLEN-1:0]   r_load_data;
  logic                     r_err;
  logic [IDXW-1:0]          r_idx;

  logic [2:0]               w_vl_clamp;
  logic                     w_width_ok;
  logic                     w_accept;
  logic [XLEN-1:0]          w_addr;
  logic [1:0]               w_a;
  logic [4:0]               w_shamt;
  logic                     w_last;
  logic [XLEN-1:0]          w_elem;
  logic [XLEN-1:0]          w_mask;
  logic [3:0]               w_be;
  logic [XLEN-1:0]          w_wdata;
  logic [XLEN-1:0]          w_rext;

  assign w_vl_clamp = (vl > 3'd4) ? 3'd4 : vl;
  assign w_width_ok = (width == W_BYTE) || (width == W_HALF) || (width == W_WORD);
  assign w_accept   = (r_state == S_IDLE) && start;
  assign w_addr     = r_base + r_off[r_idx];
  assign w_a        = w_addr[1:0];
  assign w_shamt    = {w_a, 3'b000};
  assign w_last     = ({1'b0, r_idx} == (r_vl - 3'd1));
  assign w_elem     = r_sdata[{r_idx, 5'b00000} +: XLEN];

  // Element mask, byte enables and lane-aligned write/read data for the current element
  always_comb begin
    w_mask  = 32'hFFFF_FFFF;
    w_be    = 4'b1111;
    w_wdata = w_elem;
    w_rext  = mem_rdata;
    case (r_width)
      W_WORD: begin
        w_mask  = 32'hFFFF_FFFF;
        w_be    = 4'b1111;
        w_wdata = w_elem;
        w_rext  = mem_rdata;
      end
      W_HALF: begin
        w_mask  = 32'h0000_FFFF;
        w_be    = 4'b0011 << {w_a[1], 1'b0};
        w_wdata = (w_elem & w_mask) << w_shamt;
        w_rext  = (mem_rdata >> w_shamt) & w_mask;
      end
      default: begin
        w_mask  = 32'h0000_00FF;
        w_be    = 4'b0001 << w_a;
        w_wdata = (w_elem & w_mask) << w_shamt;
        w_rext  = (mem_rdata >> w_shamt) & w_mask;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          if ((w_vl_clamp == 3'd0) || !w_width_ok) w_next = S_DONE;
          else                                      w_next = S_REQ;
        end
      end
      S_REQ: begin
        if (mem_req_ready) begin
          if (!r_is_store) w_next = S_WAIT;
          else if (w_last) w_next = S_DONE;
          else             w_next = S_REQ;
        end
      end
      S_WAIT: begin
        if (mem_rvalid) w_next = w_last ? S_DONE : S_REQ;
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Output decode; request fields only driven while a request is presented
  always_comb begin
    mem_req_valid = 1'b0;
    mem_addr      = '0;
    mem_we        = 1'b0;
    mem_be        = 4'b0000;
    mem_wdata     = '0;
    busy          = (r_state != S_IDLE);
    done          = (r_state == S_DONE);
    err           = r_err;
    load_data     = r_load_data;
    if (r_state == S_REQ) begin
      mem_req_valid = 1'b1;
      mem_addr      = w_addr;
      mem_we        = r_is_store;
      mem_be        = w_be;
      mem_wdata     = w_wdata;
    end
  end

  // Operation context, element index and load assembly
  always_ff @(posedge clk) begin
    if (rst) begin
      r_is_store  <= 1'b0;
      r_width     <= 3'b000;
      r_vl        <= 3'd0;
      r_base      <= '0;
      for (int k = 0; k < NLANES; k++) r_off[k] <= '0;
      r_sdata     <= '0;
      r_load_data <= '0;
      r_err       <= 1'b0;
      r_idx       <= '0;
    end else if (w_accept) begin
      r_is_store  <= is_store;
      r_width     <= width;
      r_vl        <= w_vl_clamp;
      r_base      <= base_addr;
      r_off[0]    <= offset0;
      r_off[1]    <= offset1;
      r_off[2]    <= offset2;
      r_off[3]    <= offset3;
      r_sdata     <= store_data;
      r_load_data <= '0;
      r_err       <= !w_width_ok;
      r_idx       <= '0;
    end else begin
      case (r_state)
        S_REQ: begin
          if (mem_req_ready && r_is_store && !w_last) r_idx <= r_idx + 2'd1;
        end
        S_WAIT: begin
          if (mem_rvalid) begin
            r_load_data[{r_idx, 5'b00000} +: XLEN] <= w_rext;
            if (!w_last) r_idx <= r_idx + 2'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_vlsu_mem_sequencer.sv
// Scoreboard bench for vlsu_mem_sequencer: directed operations push expected
// requests and completions; a negedge monitor pops and compares.
module tb_vlsu_mem_sequencer;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          is_store;
  logic [2:0]    width;
  logic [2:0]    vl;
  logic [31:0]   base_addr;
  logic [31:0]   offset0, offset1, offset2, offset3;
  logic [127:0]  store_data;
  logic          mem_req_valid;
  logic          mem_req_ready;
  logic [31:0]   mem_addr;
  logic          mem_we;
  logic [3:0]    mem_be;
  logic [31:0]   mem_wdata;
  logic          mem_rvalid;
  logic [31:0]   mem_rdata;
  logic          busy, done, err;
  logic [127:0]  load_data;

  vlsu_mem_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .is_store(is_store), .width(width),
    .vl(vl), .base_addr(base_addr), .offset0(offset0), .offset1(offset1),
    .offset2(offset2), .offset3(offset3), .store_data(store_data),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_be(mem_be), .mem_wdata(mem_wdata),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .busy(busy), .done(done),
    .err(err), .load_data(load_data)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
  } req_t;

  typedef struct packed {
    logic [127:0] ld;
    logic         err;
    logic [31:0]  cyc;
  } done_t;

  req_t  exp_req[$];
  done_t exp_done[$];

  int          checks   = 0;
  int          failures = 0;
  logic [31:0] cyc      = 0;
  logic [31:0] start_cyc = 0;

  // Memory/responder model controls
  logic        rvalid_en = 1'b0;
  logic        stall_en  = 1'b0;
  logic [31:0] key       = 32'h0;
  logic [31:0] last_addr = 32'h0;
  int          hs_count  = 0;
  int          stall_cnt = 0;

  assign mem_rvalid    = rvalid_en;
  assign mem_rdata     = last_addr ^ key;
  assign mem_req_ready = !(stall_en && (hs_count == 1) && (stall_cnt < 3));

  function automatic void chk(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endfunction

  // Cycle counter and responder bookkeeping
  always @(posedge clk) begin
    cyc <= cyc + 32'd1;
    if (mem_req_valid && mem_req_ready) last_addr <= mem_addr;
    if (start && !busy) begin
      hs_count  <= 0;
      stall_cnt <= 0;
    end else begin
      if (mem_req_valid && mem_req_ready)  hs_count  <= hs_count + 1;
      if (mem_req_valid && !mem_req_ready) stall_cnt <= stall_cnt + 1;
    end
  end

  // Monitor: request handshakes, completions and stall stability
  logic        stall_prev = 1'b0;
  logic [31:0] held_addr  = 32'h0;
  logic [3:0]  held_be    = 4'h0;
  always @(negedge clk) begin
    req_t  r;
    done_t d;
    if (rst) begin
      stall_prev <= 1'b0;
    end else begin
      if (mem_req_valid && stall_prev) begin
        chk("stall_addr", 128'(mem_addr), 128'(held_addr));
        chk("stall_be", 128'(mem_be), 128'(held_be));
      end
      stall_prev <= mem_req_valid && !mem_req_ready;
      held_addr  <= mem_addr;
      held_be    <= mem_be;
      if (mem_req_valid && mem_req_ready) begin
        if (exp_req.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_req addr=%0h required=none", mem_addr);
        end else begin
          r = exp_req.pop_front();
          chk("req_addr", 128'(mem_addr), 128'(r.addr));
          chk("req_we", 128'(mem_we), 128'(r.we));
          chk("req_be", 128'(mem_be), 128'(r.be));
          chk("req_wdata", 128'(mem_wdata), 128'(r.wdata));
        end
      end
      if (done) begin
        if (exp_done.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_done cycle=%0d required=none", cyc - start_cyc);
        end else begin
          d = exp_done.pop_front();
          chk("load_data", load_data, d.ld);
          chk("err", 128'(err), 128'(d.err));
          chk("done_cycle", 128'(cyc - start_cyc), 128'(d.cyc));
        end
      end
    end
  end

  task automatic push_req(input logic [31:0] a, input logic we, input logic [3:0] be, input logic [31:0] wd);
    req_t r;
    r.addr = a; r.we = we; r.be = be; r.wdata = wd;
    exp_req.push_back(r);
  endtask

  task automatic push_done(input logic [127:0] ld, input logic e, input logic [31:0] c);
    done_t d;
    d.ld = ld; d.err = e; d.cyc = c;
    exp_done.push_back(d);
  endtask

  // Present one start pulse; the cycle start is high is cycle 0
  task automatic do_op(input logic st, input logic [2:0] w, input logic [2:0] n,
                       input logic [31:0] b, input logic [31:0] o0, input logic [31:0] o1,
                       input logic [31:0] o2, input logic [31:0] o3, input logic [127:0] sd);
    @(posedge clk); #1;
    is_store = st; width = w; vl = n; base_addr = b;
    offset0 = o0; offset1 = o1; offset2 = o2; offset3 = o3; store_data = sd;
    start = 1'b1;
    start_cyc = cyc;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 60; i++) begin
      @(posedge clk); #1;
      if (exp_done.size() == 0 && !busy) break;
    end
    chk("pending_done", 128'(exp_done.size()), 128'(0));
    chk("pending_req", 128'(exp_req.size()), 128'(0));
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_valid"}, 128'(mem_req_valid), 128'(0));
    chk({tag, "_we"}, 128'(mem_we), 128'(0));
    chk({tag, "_be"}, 128'(mem_be), 128'(0));
    chk({tag, "_addr"}, 128'(mem_addr), 128'(0));
    chk({tag, "_wdata"}, 128'(mem_wdata), 128'(0));
    chk({tag, "_busy"}, 128'(busy), 128'(0));
    chk({tag, "_done"}, 128'(done), 128'(0));
    chk({tag, "_err"}, 128'(err), 128'(0));
    chk({tag, "_load_data"}, load_data, 128'(0));
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; is_store = 1'b0; width = 3'b000; vl = 3'd0;
    base_addr = 32'h0; offset0 = 32'h0; offset1 = 32'h0; offset2 = 32'h0; offset3 = 32'h0;
    store_data = 128'h0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    #1 chk_all_zero("reset");

    // Unit-stride word load
    rvalid_en = 1'b1; key = 32'hA5A5_A5A5;
    push_req(32'h1000, 1'b0, 4'b1111, 32'h0);
    push_req(32'h1004, 1'b0, 4'b1111, 32'h0);
    push_req(32'h1008, 1'b0, 4'b1111, 32'h0);
    push_req(32'h100C, 1'b0, 4'b1111, 32'h0);
    push_done({32'hA5A5B5A9, 32'hA5A5B5AD, 32'hA5A5B5A1, 32'hA5A5B5A5}, 1'b0, 32'd9);
    do_op(1'b0, 3'b110, 3'd4, 32'h1000, 32'h0, 32'h4, 32'h8, 32'hC, 128'h0);
    wait_idle();

    // Strided byte store, vl=3
    push_req(32'h2001, 1'b1, 4'b0010, 32'h0000_1100);
    push_req(32'h2011, 1'b1, 4'b0010, 32'h0000_2200);
    push_req(32'h2021, 1'b1, 4'b0010, 32'h0000_3300);
    push_done(128'h0, 1'b0, 32'd4);
    do_op(1'b1, 3'b000, 3'd3, 32'h2001, 32'h0, 32'h10, 32'h20, 32'h30,
          {32'h44, 32'h33, 32'h22, 32'h11});
    wait_idle();

    // Half load with 3-cycle backpressure on element 1
    stall_en = 1'b1; key = 32'h1234_5678;
    push_req(32'h4000_0000, 1'b0, 4'b0011, 32'h0);
    push_req(32'h4001_0006, 1'b0, 4'b1100, 32'h0);
    push_req(32'h4002_0002, 1'b0, 4'b1100, 32'h0);
    push_done({32'h0, 32'h5236, 32'h5235, 32'h5678}, 1'b0, 32'd10);
    do_op(1'b0, 3'b101, 3'd3, 32'h4000_0000, 32'h0, 32'h0001_0006, 32'h0002_0002, 32'h0, 128'h0);
    wait_idle();
    stall_en = 1'b0;

    // vl=0: immediate done, no requests
    push_done(128'h0, 1'b0, 32'd1);
    do_op(1'b0, 3'b110, 3'd0, 32'h1000, 32'h0, 32'h4, 32'h8, 32'hC, 128'h0);
    wait_idle();

    // Reserved width: immediate done with err, no requests
    push_done(128'h0, 1'b1, 32'd1);
    do_op(1'b1, 3'b111, 3'd4, 32'h1000, 32'h0, 32'h4, 32'h8, 32'hC, 128'h0);
    wait_idle();

    // vl=7 clamps to 4, address wraps, start while busy ignored
    key = 32'hA5A5_A5A5;
    push_req(32'hFFFF_FFFC, 1'b0, 4'b1111, 32'h0);
    push_req(32'h0000_0000, 1'b0, 4'b1111, 32'h0);
    push_req(32'h0000_0004, 1'b0, 4'b1111, 32'h0);
    push_req(32'h0000_0008, 1'b0, 4'b1111, 32'h0);
    push_done({32'hA5A5A5AD, 32'hA5A5A5A1, 32'hA5A5A5A5, 32'h5A5A5A59}, 1'b0, 32'd9);
    do_op(1'b0, 3'b110, 3'd7, 32'hFFFF_FFFC, 32'h0, 32'h4, 32'h8, 32'hC, 128'h0);
    @(posedge clk); #1;
    is_store = 1'b1; width = 3'b000; vl = 3'd1; base_addr = 32'h7777_0000;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_idle();

    // Reset while waiting for a load response
    rvalid_en = 1'b0; key = 32'h0F0F_0F0F;
    push_req(32'h5000, 1'b0, 4'b1111, 32'h0);
    do_op(1'b0, 3'b110, 3'd2, 32'h5000, 32'h0, 32'h4, 32'h0, 32'h0, 128'h0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk_all_zero("abort");
    chk("abort_pending_req", 128'(exp_req.size()), 128'(0));
    rvalid_en = 1'b1;
    repeat (3) @(posedge clk);
    #1 chk("late_rvalid_load_data", load_data, 128'(0));
    chk("late_rvalid_busy", 128'(busy), 128'(0));

    // Fresh word store after the abort completes normally
    push_req(32'h6000, 1'b1, 4'b1111, 32'hDEAD_BEEF);
    push_done(128'h0, 1'b0, 32'd2);
    do_op(1'b1, 3'b110, 3'd1, 32'h6000, 32'h0, 32'h0, 32'h0, 32'h0, {96'h0, 32'hDEAD_BEEF});
    wait_idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
